// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, producing cos/sin
// of a Q3.29 angle as Q2.30 results with quadrant folding and output saturation.
module cordic_sincos #(
   parameter int WIDTH = 32,
   parameter int ITER  = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] angle,
   output logic signed [WIDTH-1:0] fn1,
   output logic signed [WIDTH-1:0] fn2,
   output logic                    done,
   output logic                    busy
);

   localparam int WW = WIDTH + 2;
   localparam int CW = $clog2(ITER);

   localparam logic signed [WW-1:0] PI_2    = WW'(843314857);
   localparam logic signed [WW-1:0] PI      = WW'(1686629713);
   localparam logic signed [WW-1:0] K_GAIN  = WW'(652032874);
   localparam logic signed [WW-1:0] SAT_MAX = WW'(64'sd1 << (WIDTH - 2));
   localparam logic signed [WW-1:0] SAT_MIN = -SAT_MAX;
   localparam logic [CW-1:0]        I_LAST  = CW'(ITER - 1);

   typedef enum logic [1:0] {IDLE, ROTATE, FINISH} state_t;

   // round(atan(2^-i) * 2^29)
   function automatic logic signed [WW-1:0] atan_rom(input int idx);
      logic [31:0] v;
      case (idx)
         0:  v = 32'd421657428;
         1:  v = 32'd248918915;
         2:  v = 32'd131521918;
         3:  v = 32'd66762579;
         4:  v = 32'd33510843;
         5:  v = 32'd16771758;
         6:  v = 32'd8387925;
         7:  v = 32'd4194219;
         8:  v = 32'd2097141;
         9:  v = 32'd1048575;
         10: v = 32'd524288;
         11: v = 32'd262144;
         12: v = 32'd131072;
         13: v = 32'd65536;
         14: v = 32'd32768;
         15: v = 32'd16384;
         16: v = 32'd8192;
         17: v = 32'd4096;
         18: v = 32'd2048;
         19: v = 32'd1024;
         20: v = 32'd512;
         21: v = 32'd256;
         22: v = 32'd128;
         23: v = 32'd64;
         24: v = 32'd32;
         25: v = 32'd16;
         26: v = 32'd8;
         27: v = 32'd4;
         28: v = 32'd2;
         29: v = 32'd1;
         default: v = 32'd0;
      endcase
      return WW'(v);
   endfunction

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [WW-1:0] v);
      logic signed [WW-1:0] c;
      if (v > SAT_MAX)
         c = SAT_MAX;
      else if (v < SAT_MIN)
         c = SAT_MIN;
      else
         c = v;
      return c[WIDTH-1:0];
   endfunction

   logic signed [WW-1:0] atan_tab [ITER];

   for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
      assign atan_tab[gi] = atan_rom(gi);
   end

   state_t                  state_reg, state_next;
   logic signed [WW-1:0]    x_reg, x_next;
   logic signed [WW-1:0]    y_reg, y_next;
   logic signed [WW-1:0]    z_reg, z_next;
   logic [CW-1:0]           i_reg, i_next;
   logic                    neg_reg, neg_next;
   logic signed [WIDTH-1:0] fn1_reg, fn1_next;
   logic signed [WIDTH-1:0] fn2_reg, fn2_next;
   logic                    done_reg, done_next;
   logic                    busy_reg, busy_next;

   logic signed [WW-1:0]    angle_ext;
   logic signed [WW-1:0]    x_sh, y_sh;

   assign angle_ext = WW'(angle);
   assign x_sh      = x_reg >>> i_reg;
   assign y_sh      = y_reg >>> i_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         x_reg     <= '0;
         y_reg     <= '0;
         z_reg     <= '0;
         i_reg     <= '0;
         neg_reg   <= 1'b0;
         fn1_reg   <= '0;
         fn2_reg   <= '0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         z_reg     <= z_next;
         i_reg     <= i_next;
         neg_reg   <= neg_next;
         fn1_reg   <= fn1_next;
         fn2_reg   <= fn2_next;
         done_reg  <= done_next;
         busy_reg  <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      z_next     = z_reg;
      i_next     = i_reg;
      neg_next   = neg_reg;
      fn1_next   = fn1_reg;
      fn2_next   = fn2_reg;
      done_next  = 1'b0;
      busy_next  = busy_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               // Fold into [-pi/2, pi/2]; the half-turn is undone by negating the result.
               if (angle_ext > PI_2) begin
                  z_next   = angle_ext - PI;
                  neg_next = 1'b1;
               end else if (angle_ext < -PI_2) begin
                  z_next   = angle_ext + PI;
                  neg_next = 1'b1;
               end else begin
                  z_next   = angle_ext;
                  neg_next = 1'b0;
               end
               x_next     = K_GAIN;
               y_next     = '0;
               i_next     = '0;
               busy_next  = 1'b1;
               state_next = ROTATE;
            end
         end

         ROTATE: begin
            if (!z_reg[WW-1]) begin
               x_next = x_reg - y_sh;
               y_next = y_reg + x_sh;
               z_next = z_reg - atan_tab[i_reg];
            end else begin
               x_next = x_reg + y_sh;
               y_next = y_reg - x_sh;
               z_next = z_reg + atan_tab[i_reg];
            end
            if (i_reg == I_LAST)
               state_next = FINISH;
            else
               i_next = i_reg + 1'b1;
         end

         FINISH: begin
            fn1_next   = sat(neg_reg ? -x_reg : x_reg);
            fn2_next   = sat(neg_reg ? -y_reg : y_reg);
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   assign fn1  = fn1_reg;
   assign fn2  = fn2_reg;
   assign done = done_reg;
   assign busy = busy_reg;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: reset state, latency, folding, busy-time starts,
// async abort and a random angle sweep against a real-valued sin/cos model.
module tb_cordic_sincos;

   localparam int  WIDTH = 32;
   localparam int  ITER  = 24;
   localparam int  TOL   = 256;
   localparam int  PI    = 1686629713;
   localparam int  PI_2  = 843314857;
   localparam int  PI_4  = 421657428;
   localparam int  PI_6  = 281104952;
   localparam longint ONE   = 1073741824;
   localparam longint COS30 = 929887697;
   localparam longint SIN30 = 536870912;
   localparam longint COS45 = 759250125;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic signed [WIDTH-1:0] angle;
   logic signed [WIDTH-1:0] fn1;
   logic signed [WIDTH-1:0] fn2;
   logic                    done;
   logic                    busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cordic_sincos #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .angle (angle),
      .fn1   (fn1),
      .fn2   (fn2),
      .done  (done),
      .busy  (busy)
   );

   task automatic chk_eq(input string tag, input longint act, input longint exp);
      n_cmp++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input longint act, input longint exp);
      longint diff;
      diff = act - exp;
      if (diff < 0) diff = -diff;
      n_cmp++;
      assert (diff <= TOL) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, act, exp, TOL);
      end
   endtask

   // Drive a start pulse from just after a rising edge; returns just after the accept edge.
   task automatic launch(input int a);
      angle = a;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Edges until done is seen high, bounded so a hung FSM still reaches the summary.
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!done && lat < 100);
   endtask

   task automatic run_check(input string tag, input int a, input longint ec, input longint es);
      int lat;
      launch(a);
      chk_eq({tag, "_busy_run"}, longint'(busy), 1);
      wait_done(lat);
      chk_eq({tag, "_latency"}, lat, ITER + 1);
      chk_tol({tag, "_fn1"}, fn1, ec);
      chk_tol({tag, "_fn2"}, fn2, es);
      @(posedge clk);
      #1;
      chk_eq({tag, "_done_pulse"}, longint'(done), 0);
      chk_eq({tag, "_busy_after"}, longint'(busy), 0);
      $display("run %s angle=%0d fn1=%0d fn2=%0d lat=%0d", tag, a, fn1, fn2, lat);
   endtask

   initial begin
      int     lat;
      int     seen;
      longint v;
      real    r;

      rst   = 1'b1;
      start = 1'b0;
      angle = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_fn1", fn1, 0);
      chk_eq("rst_fn2", fn2, 0);
      chk_eq("rst_done", longint'(done), 0);
      chk_eq("rst_busy", longint'(busy), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_check("zero", 0, ONE, 0);
      run_check("pi_6", PI_6, COS30, SIN30);
      run_check("pi", PI, -ONE, 0);
      run_check("neg_pi_2", -PI_2, 0, -ONE);

      // start and angle change mid-run must be ignored
      launch(PI_4);
      repeat (4) @(posedge clk);
      #1;
      angle = -PI_2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_eq("ign_busy", longint'(busy), 1);
      wait_done(lat);
      chk_eq("ign_latency", lat + 5, ITER + 1);
      chk_tol("ign_fn1", fn1, COS45);
      chk_tol("ign_fn2", fn2, COS45);
      $display("run ignored_start angle=%0d fn1=%0d fn2=%0d lat=%0d", PI_4, fn1, fn2, lat + 5);

      // start while done is high launches the next run immediately
      launch(-PI_6);
      chk_eq("dcyc_busy", longint'(busy), 1);
      wait_done(lat);
      chk_eq("dcyc_latency", lat, ITER + 1);
      chk_tol("dcyc_fn1", fn1, COS30);
      chk_tol("dcyc_fn2", fn2, -SIN30);
      $display("run done_cycle_start angle=%0d fn1=%0d fn2=%0d lat=%0d", -PI_6, fn1, fn2, lat);
      @(posedge clk);
      #1;
      chk_eq("dcyc_done_pulse", longint'(done), 0);

      // asynchronous abort at iteration 10
      launch(PI_6);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_eq("abort_fn1", fn1, 0);
      chk_eq("abort_fn2", fn2, 0);
      chk_eq("abort_busy", longint'(busy), 0);
      chk_eq("abort_done", longint'(done), 0);
      repeat (2) @(posedge clk);
      #1;
      rst  = 1'b0;
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk_eq("abort_no_done", seen, 0);
      $display("run abort angle=%0d done_seen=%0d", PI_6, seen);
      run_check("after_abort", 0, ONE, 0);

      for (int k = 0; k < 64; k++) begin
         v = longint'($urandom_range(32'd3373259426)) - longint'(PI);
         r = real'(v) / 536870912.0;
         run_check("sweep", int'(v), longint'($cos(r) * 1073741824.0),
                   longint'($sin(r) * 1073741824.0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
